// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM loader slice.
// Holds the loader FSM state enum, length/word widths and byte-index width.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN adds the CHK state.
package rom_loader_pkg;

  localparam int LEN_W  = 16;  // word-count field carried in the stream header
  localparam int WORD_W = 32;  // ROM word width
  localparam int BIDX_W = 2;   // byte index within a word (4 bytes)

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_e;

  // State entered once the last word is written (or immediately for N=0).
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_e LOAD_END = CHK;
`else
  localparam state_e LOAD_END = DONE;
`endif

endpackage

// File: rtl/rom_word_packer.sv
// rom_word_packer: assembles accepted bytes into little-endian 32-bit words.
// Ports: clk/rest clock and async active-low reset; clr_i restarts assembly;
//   byte_vld_i/byte_i accepted byte; full_o high while the 4th byte is taken;
//   word_o is the word including the byte being accepted this cycle.
module rom_word_packer
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rest,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic              full_o,
  output logic [WORD_W-1:0] word_o
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;

  // Shift right so the first byte of a word ends up in bits [7:0].
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clr_i) begin
      idx_d   = '0;
      shreg_d = '0;
    end else if (byte_vld_i) begin
      idx_d   = idx_q + BIDX_W'(1);  // wraps to 0 after the 4th byte
      shreg_d = {byte_i, shreg_q[WORD_W-1:8]};
    end
  end

  // Combinational so the FSM can capture the word on the same edge.
  assign full_o = byte_vld_i && (idx_q == '1);
  assign word_o = shreg_d;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: loads a length-prefixed byte stream into instruction ROM and
// controls CPU reset. Ports: byte stream rx_*, ROM write port rom_*,
// cpu_rest_o (active-low CPU reset, registered), busy_o/done_o/err_o status.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int ROM_DEPTH = 4096,
  parameter int BOOT_HOLD = 1
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [WORD_W-1:0] rom_wdata_o,
  output logic              cpu_rest_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic             IDLE_REL = (BOOT_HOLD == 0);
  localparam logic [LEN_W:0]   DEPTH_L  = (LEN_W + 1)'(ROM_DEPTH);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [LEN_W-1:0]    n_len;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                cpu_rest_q, cpu_rest_d;
  logic                rx_rdy, acc;
  logic                pk_clr, pk_full;
  logic [WORD_W-1:0]   pk_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  // Ready depends on state only, so a byte offered elsewhere simply waits.
  always_comb begin
    rx_rdy = 1'b0;
    case (state_q)
      LEN0, LEN1, DATA: rx_rdy = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK:              rx_rdy = 1'b1;
`endif
      default:          rx_rdy = 1'b0;
    endcase
  end

  assign acc = rx_valid_i && rx_rdy;

  rom_word_packer u_packer (
    .clk        (clk),
    .rest       (rest),
    .clr_i      (pk_clr),
    .byte_vld_i (acc && (state_q == DATA)),
    .byte_i     (rx_data_i),
    .full_o     (pk_full),
    .word_o     (pk_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pk_clr  = 1'b0;
    n_len   = {rx_data_i, len_q[7:0]};
    cnt_inc = cnt_q + LEN_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LEN0;
          len_d   = '0;
          cnt_d   = '0;
          pk_clr  = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      LEN0: begin
        if (acc) begin
          len_d[7:0] = rx_data_i;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (acc) begin
          len_d = n_len;
          if (n_len == '0)                    state_d = LOAD_END;
          else if ({1'b0, n_len} > DEPTH_L)   state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA: begin
        // Address/data are captured here so they stay stable after WRITE.
        if (pk_full) begin
          state_d = WRITE;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = pk_word;
        end
      end
      WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc < len_q) ? DATA : LOAD_END;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK: begin
        if (acc) state_d = (rx_data_i == xor_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum covers length and data bytes, not the checksum byte itself.
    if (acc && (state_q != CHK)) xor_d = xor_q ^ rx_data_i;
`endif
  end

  // CPU reset follows the next state so the flop matches the state register.
  always_comb begin
    case (state_d)
      IDLE:    cpu_rest_d = IDLE_REL;
      DONE:    cpu_rest_d = 1'b1;
      default: cpu_rest_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rest_q <= IDLE_REL;
`ifdef ROM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rest_q <= cpu_rest_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    busy_o = 1'b0;
    case (state_q)
      LEN0, LEN1, DATA, WRITE: busy_o = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      CHK:                     busy_o = 1'b1;
`endif
      default:                 busy_o = 1'b0;
    endcase
  end

  assign rx_ready_o  = rx_rdy;
  assign rom_we_o    = (state_q == WRITE);
  assign rom_waddr_o = waddr_q;
  assign rom_wdata_o = wdata_q;
  assign cpu_rest_o  = cpu_rest_q;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERR);

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven directed bench for rom_loader (default params).
// Streams length-prefixed images, watches the ROM write port and status.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN switches the stream tables.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rest;
  logic        start_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        rom_we_o;
  logic [11:0] rom_waddr_o;
  logic [31:0] rom_wdata_o;
  logic        cpu_rest_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  rom_loader dut (
    .clk         (clk),
    .rest        (rest),
    .start_i     (start_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .rom_we_o    (rom_we_o),
    .rom_waddr_o (rom_waddr_o),
    .rom_wdata_o (rom_wdata_o),
    .cpu_rest_o  (cpu_rest_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nwr      = 0;
  logic [11:0] wa [8];
  logic [31:0] wd [8];
  int          wc [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Write-port monitor: logs every write and checks hold-off during WRITE.
  always @(negedge clk) begin
    if (rest === 1'b1 && rom_we_o === 1'b1) begin
      if (nwr < 8) begin
        wa[nwr] = rom_waddr_o;
        wd[nwr] = rom_wdata_o;
        wc[nwr] = cyc;
      end
      nwr++;
      if (rx_valid_i) chk("ready_low_in_write", 32'(rx_ready_o), 32'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rx_ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  // Byte i of the stream sits in bv[8*i +: 8]; valid stays high throughout.
  task automatic send_bytes(input logic [95:0] bv, input int n);
    for (int i = 0; i < n; i++) send(bv[8*i +: 8]);
    rx_valid_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  typedef struct {
    logic [95:0] bv;
    int          n;
    int          lat;
    bit          e_done;
    bit          e_err;
    bit          e_busy;
    bit          e_crst;
    int          e_nwr;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vt [6];
  int   nv;

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ROM_LOADER_CHECKSUM_EN
    vt[0] = '{96'h92_0010_0093_0000_0013_0002, 11, 1, 1, 0, 0, 1, 2, 32'h0000_0013, 32'h0010_0093};
    vt[1] = '{96'h1001,                          2, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0};
    vt[2] = '{96'h00_0000,                       3, 1, 1, 0, 0, 1, 0, 32'h0, 32'h0};
    vt[3] = '{96'h23_DEAD_BEEF_0001,             7, 1, 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0};
    vt[4] = '{96'h93_0010_0093_0000_0013_0002, 11, 1, 0, 1, 0, 0, 2, 32'h0000_0013, 32'h0010_0093};
    vt[5] = '{96'h1000,                          2, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0};
    nv = 6;
`else
    vt[0] = '{96'h0010_0093_0000_0013_0002,    10, 2, 1, 0, 0, 1, 2, 32'h0000_0013, 32'h0010_0093};
    vt[1] = '{96'h1001,                          2, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0};
    vt[2] = '{96'h0000,                          2, 1, 1, 0, 0, 1, 0, 32'h0, 32'h0};
    vt[3] = '{96'hDEAD_BEEF_0001,                6, 2, 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0};
    vt[4] = '{96'h1000,                          2, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0};
    nv = 5;
`endif

    rest = 1'b0; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    #12;
    chk("rst_busy",     32'(busy_o),      32'd0);
    chk("rst_done",     32'(done_o),      32'd0);
    chk("rst_err",      32'(err_o),       32'd0);
    chk("rst_ready",    32'(rx_ready_o),  32'd0);
    chk("rst_we",       32'(rom_we_o),    32'd0);
    chk("rst_waddr",    32'(rom_waddr_o), 32'd0);
    chk("rst_wdata",    rom_wdata_o,      32'd0);
    chk("rst_cpu_rest", 32'(cpu_rest_o),  32'd0);
    @(posedge clk); #1;
    rest = 1'b1;

    for (int i = 0; i < nv; i++) begin
      nwr = 0;
      do_start();
      chk($sformatf("v%0d_busy_after_start", i), 32'(busy_o),     32'd1);
      chk($sformatf("v%0d_flags_cleared", i),    32'({done_o, err_o}), 32'd0);
      chk($sformatf("v%0d_cpu_held", i),         32'(cpu_rest_o), 32'd0);
      send_bytes(vt[i].bv, vt[i].n);
      repeat (vt[i].lat) @(negedge clk);
      chk($sformatf("v%0d_done", i),     32'(done_o),     32'(vt[i].e_done));
      chk($sformatf("v%0d_err", i),      32'(err_o),      32'(vt[i].e_err));
      chk($sformatf("v%0d_busy", i),     32'(busy_o),     32'(vt[i].e_busy));
      chk($sformatf("v%0d_cpu_rest", i), 32'(cpu_rest_o), 32'(vt[i].e_crst));
      @(posedge clk); #1;
      chk($sformatf("v%0d_nwr", i), 32'(nwr), 32'(vt[i].e_nwr));
      if (vt[i].e_nwr >= 1) begin
        chk($sformatf("v%0d_addr0", i), 32'(wa[0]), 32'd0);
        chk($sformatf("v%0d_data0", i), wd[0],      vt[i].d0);
      end
      if (vt[i].e_nwr >= 2) begin
        chk($sformatf("v%0d_addr1", i),  32'(wa[1]),       32'd1);
        chk($sformatf("v%0d_data1", i),  wd[1],            vt[i].d1);
        chk($sformatf("v%0d_period", i), 32'(wc[1] - wc[0]), 32'd5);
      end
    end

    // N=4096 is accepted and loading; a start here must be ignored.
    do_start();
    chk("ign_start_busy", 32'(busy_o), 32'd1);
    send_bytes(96'h1234_5678, 4);
    @(negedge clk);
    chk("ign_start_we",    32'(rom_we_o),    32'd1);
    chk("ign_start_waddr", 32'(rom_waddr_o), 32'd0);
    chk("ign_start_wdata", rom_wdata_o,      32'h1234_5678);
    @(negedge clk);
    chk("hold_we",    32'(rom_we_o),    32'd0);
    chk("hold_wdata", rom_wdata_o,      32'h1234_5678);
    chk("hold_busy",  32'(busy_o),      32'd1);
    @(posedge clk); #1;

    // Reset mid-load after 5 bytes, then restart with N=1.
    rest = 1'b0;
    #2;
    rest = 1'b1;
    @(posedge clk); #1;
    do_start();
    send(8'h04); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    #2;
    rest = 1'b0;
    rx_valid_i = 1'b0;
    #1;
    chk("mid_rst_busy",     32'(busy_o),      32'd0);
    chk("mid_rst_ready",    32'(rx_ready_o),  32'd0);
    chk("mid_rst_we",       32'(rom_we_o),    32'd0);
    chk("mid_rst_waddr",    32'(rom_waddr_o), 32'd0);
    chk("mid_rst_wdata",    rom_wdata_o,      32'd0);
    chk("mid_rst_cpu_rest", 32'(cpu_rest_o),  32'd0);
    chk("mid_rst_flags",    32'({done_o, err_o}), 32'd0);
    @(posedge clk); #1;
    rest = 1'b1;
    nwr = 0;
    // Byte offered in IDLE must wait, then become the first length byte.
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_holdoff_ready", 32'(rx_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    do_start();
`ifdef ROM_LOADER_CHECKSUM_EN
    send_bytes(96'h01_DDCC_BBAA_0001, 7);
    @(negedge clk);
`else
    send_bytes(96'hDDCC_BBAA_0001, 6);
    @(negedge clk);
    @(negedge clk);
`endif
    chk("restart_done",     32'(done_o),     32'd1);
    chk("restart_cpu_rest", 32'(cpu_rest_o), 32'd1);
    @(posedge clk); #1;
    chk("restart_nwr",   32'(nwr),   32'd1);
    chk("restart_addr0", 32'(wa[0]), 32'd0);
    chk("restart_data0", wd[0],      32'hDDCC_BBAA);

    // DONE is sticky while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("done_sticky", 32'(done_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
